led_mem_arbiter: RTL and testbench

- Shares the single-port 16x16 led_mem block RAM between two requesters:
  - m0: the button-driven write/read controller.
  - m1: a free-running LED playback/scan engine.
- Round-robin arbitration grants one memory access per cycle and drives the RAM's ena/wea/addra/dina registers.
- Tracks in-flight reads through the RAM's 1-cycle latency and returns read data to the requester that issued the read.

---
 rtl/led_mem_arbiter_pkg.sv | 19 +
 rtl/led_mem_arbiter_if.sv | 25 ++
 rtl/led_mem_arbiter_rr_arbiter2.sv | 52 +++++
 rtl/led_mem_arbiter.sv | 110 +++++++++++
 tb/tb_led_mem_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_mem_arbiter_pkg.sv
// Shared constants and types for the led_mem block RAM arbiter.
package led_mem_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    // Which requester an access or read response belongs to.
    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

    // Tag that follows an issued read through the RAM latency.
    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/led_mem_arbiter_if.sv
// Request/response channel between one requester and the led_mem arbiter.
interface led_mem_arbiter_if;
    import led_mem_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    // Requester side: holds req and its fields until gnt.
    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata, rvalid
    );

    // Arbiter side.
    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata, rvalid
    );

endinterface

// File: rtl/led_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: grant is combinational from req and the
// last-granted register, which only moves when a grant is actually issued.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   LAST_M0 | m0 was granted most recently; m1 wins a tie
//   LAST_M1 | m1 was granted most recently; m0 wins a tie
//           | (reset state, so m0 wins the first conflict)
module rr_arbiter2 (
    input  logic       clk_g,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    typedef enum logic {
        LAST_M0 = 1'b0,
        LAST_M1 = 1'b1
    } rr_state_t;

    rr_state_t state;
    rr_state_t state_next;

    // Last-granted register.
    always_ff @(posedge clk_g) begin
        if (!rst) begin
            state <= LAST_M1;
        end else begin
            state <= state_next;
        end
    end

    // Grant decision and pointer update; no grants while reset is asserted.
    always_comb begin
        gnt        = 2'b00;
        state_next = state;
        if (rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (state == LAST_M1) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
            if (gnt[0]) begin
                state_next = LAST_M0;
            end else if (gnt[1]) begin
                state_next = LAST_M1;
            end
        end
    end

endmodule

// File: rtl/led_mem_arbiter.sv
// Shares the single-port led_mem block RAM between the button controller
// (m0) and the LED playback engine (m1). One access is issued per cycle;
// read responses are steered back to the issuing requester three cycles
// after its grant.
module led_mem_arbiter
    import led_mem_pkg::*;
(
    input  logic                clk_g,
    input  logic                rst,
    led_mem_arbiter_if.slave    m0,
    led_mem_arbiter_if.slave    m1,
    output logic                ena,
    output logic                wea,
    output logic [ADDR_W-1:0]   addra,
    output logic [DATA_W-1:0]   dina,
    input  logic [DATA_W-1:0]   douta
);

    logic [1:0]        gnt;
    logic              any_gnt;
    master_id_t        sel_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rd_tag_t           tag_s1;
    rd_tag_t           tag_s2;

    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid0;
    logic              rvalid1;

    rr_arbiter2 u_rr (
        .clk_g (clk_g),
        .rst   (rst),
        .req   ({m1.req, m0.req}),
        .gnt   (gnt)
    );

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    assign m0.rdata  = rdata0;
    assign m1.rdata  = rdata1;
    assign m0.rvalid = rvalid0;
    assign m1.rvalid = rvalid1;
    assign any_gnt   = gnt[0] | gnt[1];

    // Select the granted requester's access fields.
    always_comb begin
        sel_id    = M0;
        sel_we    = m0.we;
        sel_addr  = m0.addr;
        sel_wdata = m0.wdata;
        if (gnt[1]) begin
            sel_id    = M1;
            sel_we    = m1.we;
            sel_addr  = m1.addr;
            sel_wdata = m1.wdata;
        end
    end

    // RAM issue registers; address/data hold when nothing is granted.
    always_ff @(posedge clk_g) begin
        if (!rst) begin
            ena   <= 1'b0;
            wea   <= 1'b0;
            addra <= '0;
            dina  <= '0;
        end else begin
            ena <= any_gnt;
            wea <= any_gnt & sel_we;
            if (any_gnt) begin
                addra <= sel_addr;
                dina  <= sel_wdata;
            end
        end
    end

    // Read tags: stage 1 lines up with the RAM address cycle, stage 2 with douta.
    always_ff @(posedge clk_g) begin
        if (!rst) begin
            tag_s1 <= '{valid: 1'b0, id: M0};
            tag_s2 <= '{valid: 1'b0, id: M0};
        end else begin
            tag_s1 <= '{valid: any_gnt & ~sel_we, id: sel_id};
            tag_s2 <= tag_s1;
        end
    end

    // Response demux: capture douta for the tagged requester, strobe rvalid.
    always_ff @(posedge clk_g) begin
        if (!rst) begin
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= tag_s2.valid && (tag_s2.id == M0);
            rvalid1 <= tag_s2.valid && (tag_s2.id == M1);
            if (tag_s2.valid && (tag_s2.id == M0)) begin
                rdata0 <= douta;
            end
            if (tag_s2.valid && (tag_s2.id == M1)) begin
                rdata1 <= douta;
            end
        end
    end

endmodule

// File: tb/tb_led_mem_arbiter.sv
// Self-checking bench for led_mem_arbiter with a behavioural 16x16 RAM.
module tb_led_mem_arbiter;
    import led_mem_pkg::*;

    logic        clk_g = 1'b0;
    logic        rst;
    logic        ena, wea;
    logic [3:0]  addra;
    logic [15:0] dina;
    logic [15:0] douta = '0;
    logic [15:0] ram [16];
    logic        ram_loaded = 1'b0;

    int checks   = 0;
    int failures = 0;

    led_mem_arbiter_if m0_bus ();
    led_mem_arbiter_if m1_bus ();

    led_mem_arbiter dut (
        .clk_g (clk_g),
        .rst   (rst),
        .m0    (m0_bus.slave),
        .m1    (m1_bus.slave),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta)
    );

    always #5 clk_g = ~clk_g;

    // Single-port RAM, 1-cycle read latency; preloaded with 16'hC000 | addr.
    always @(posedge clk_g) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram[i] <= 16'hC000 | 16'(i);
            ram_loaded <= 1'b1;
        end else if (ena) begin
            if (wea) ram[addra] <= dina;
            douta <= ram[addra];
        end
    end

    typedef struct {
        logic        r0, w0; logic [3:0] a0; logic [15:0] d0;
        logic        r1, w1; logic [3:0] a1; logic [15:0] d1;
        logic        g0, g1, en, we; logic [3:0] addr; logic [15:0] din;
        logic        v0; logic [15:0] rd0;
        logic        v1; logic [15:0] rd1;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(
        logic r0, logic w0, logic [3:0] a0, logic [15:0] d0,
        logic r1, logic w1, logic [3:0] a1, logic [15:0] d1,
        logic g0, logic g1, logic en, logic we, logic [3:0] addr, logic [15:0] din,
        logic v0, logic [15:0] rd0, logic v1, logic [15:0] rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.en = en; v.we = we; v.addr = addr; v.din = din;
        v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [3:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [3:0] a1, input logic [15:0] d1);
        m0_bus.req = r0; m0_bus.we = w0; m0_bus.addr = a0; m0_bus.wdata = d0;
        m1_bus.req = r1; m1_bus.we = w1; m1_bus.addr = a1; m1_bus.wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0);
    endtask

    initial begin
        int  cnt0, cnt1;
        int  gk;
        logic exp_g1;

        // Cycle-by-cycle table: inputs of the cycle, outputs seen in that cycle.
        //               m0 req/we/addr/wdata     m1 req/we/addr/wdata      g0 g1 en we addra dina       v0 rd0        v1 rd1
        vecs[0]  = mk(1,0,4'd2,16'h0,     1,0,4'd5,16'h0,     1,0,0,0,4'd0,16'h0,     0,16'h0,    0,16'h0);
        vecs[1]  = mk(0,0,4'd0,16'h0,     1,0,4'd5,16'h0,     0,1,1,0,4'd2,16'h0,     0,16'h0,    0,16'h0);
        vecs[2]  = mk(0,0,4'd0,16'h0,     0,0,4'd0,16'h0,     0,0,1,0,4'd5,16'h0,     0,16'h0,    0,16'h0);
        vecs[3]  = mk(0,0,4'd0,16'h0,     0,0,4'd0,16'h0,     0,0,0,0,4'd5,16'h0,     1,16'hC002, 0,16'h0);
        vecs[4]  = mk(0,0,4'd0,16'h0,     0,0,4'd0,16'h0,     0,0,0,0,4'd5,16'h0,     0,16'hC002, 1,16'hC005);
        vecs[5]  = mk(1,1,4'd3,16'hA5A5,  0,0,4'd0,16'h0,     1,0,0,0,4'd5,16'h0,     0,16'hC002, 0,16'hC005);
        vecs[6]  = mk(1,0,4'd3,16'h0,     0,0,4'd0,16'h0,     1,0,1,1,4'd3,16'hA5A5,  0,16'hC002, 0,16'hC005);
        vecs[7]  = mk(0,0,4'd0,16'h0,     0,0,4'd0,16'h0,     0,0,1,0,4'd3,16'h0,     0,16'hC002, 0,16'hC005);
        vecs[8]  = mk(0,0,4'd0,16'h0,     0,0,4'd0,16'h0,     0,0,0,0,4'd3,16'h0,     0,16'hC002, 0,16'hC005);
        vecs[9]  = mk(0,0,4'd0,16'h0,     0,0,4'd0,16'h0,     0,0,0,0,4'd3,16'h0,     1,16'hA5A5, 0,16'hC005);
        vecs[10] = mk(0,0,4'd0,16'h0,     1,1,4'd7,16'h00FF,  0,1,0,0,4'd3,16'h0,     0,16'hA5A5, 0,16'hC005);
        vecs[11] = mk(1,0,4'd7,16'h0,     0,0,4'd0,16'h0,     1,0,1,1,4'd7,16'h00FF,  0,16'hA5A5, 0,16'hC005);
        vecs[12] = mk(0,0,4'd0,16'h0,     0,0,4'd0,16'h0,     0,0,1,0,4'd7,16'h0,     0,16'hA5A5, 0,16'hC005);
        vecs[13] = mk(0,0,4'd0,16'h0,     0,0,4'd0,16'h0,     0,0,0,0,4'd7,16'h0,     0,16'hA5A5, 0,16'hC005);
        vecs[14] = mk(0,0,4'd0,16'h0,     0,0,4'd0,16'h0,     0,0,0,0,4'd7,16'h0,     1,16'h00FF, 0,16'hC005);

        // Reset with both requesting: no grants, outputs at reset values.
        rst = 1'b0;
        drive(1, 0, 4'd0, 16'h0, 1, 0, 4'd0, 16'h0);
        repeat (3) @(negedge clk_g);
        #1;
        chk("rst.g0", 32'(m0_bus.gnt), 0);
        chk("rst.g1", 32'(m1_bus.gnt), 0);
        chk("rst.ena", 32'(ena), 0);
        chk("rst.addra", 32'(addra), 0);
        chk("rst.rv0", 32'(m0_bus.rvalid), 0);

        // Simultaneous reads, write/read by m0, cross-master write/read.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_g);
            if (i == 0) rst = 1'b1;
            drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            #1;
            chk($sformatf("v%0d.g0", i),    32'(m0_bus.gnt),    32'(vecs[i].g0));
            chk($sformatf("v%0d.g1", i),    32'(m1_bus.gnt),    32'(vecs[i].g1));
            chk($sformatf("v%0d.ena", i),   32'(ena),           32'(vecs[i].en));
            chk($sformatf("v%0d.wea", i),   32'(wea),           32'(vecs[i].we));
            chk($sformatf("v%0d.addra", i), 32'(addra),         32'(vecs[i].addr));
            chk($sformatf("v%0d.dina", i),  32'(dina),          32'(vecs[i].din));
            chk($sformatf("v%0d.rv0", i),   32'(m0_bus.rvalid), 32'(vecs[i].v0));
            chk($sformatf("v%0d.rd0", i),   32'(m0_bus.rdata),  32'(vecs[i].rd0));
            chk($sformatf("v%0d.rv1", i),   32'(m1_bus.rvalid), 32'(vecs[i].v1));
            chk($sformatf("v%0d.rd1", i),   32'(m1_bus.rdata),  32'(vecs[i].rd1));
        end

        // Continuous contention for 10 cycles; m0 was granted last, so m1 leads.
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk_g);
            if (k < 10) drive(1, 0, 4'd1, 16'h0, 1, 0, 4'd4, 16'h0);
            else        idle();
            #1;
            if (m0_bus.gnt) cnt0++;
            if (m1_bus.gnt) cnt1++;
            if (k < 10) begin
                exp_g1 = ((k % 2) == 0);
                chk($sformatf("alt%0d.g0", k), 32'(m0_bus.gnt), 32'(!exp_g1));
                chk($sformatf("alt%0d.g1", k), 32'(m1_bus.gnt), 32'(exp_g1));
            end
            chk($sformatf("alt%0d.ena", k), 32'(ena), 32'((k >= 1) && (k <= 10)));
            gk = k - 3;
            if (gk >= 0 && gk <= 9) begin
                chk($sformatf("alt%0d.rv0", k), 32'(m0_bus.rvalid), 32'((gk % 2) == 1));
                chk($sformatf("alt%0d.rv1", k), 32'(m1_bus.rvalid), 32'((gk % 2) == 0));
                if ((gk % 2) == 1) chk($sformatf("alt%0d.rd0", k), 32'(m0_bus.rdata), 32'h0000C001);
                else               chk($sformatf("alt%0d.rd1", k), 32'(m1_bus.rdata), 32'h0000C004);
            end else begin
                chk($sformatf("alt%0d.rvany", k), 32'(m0_bus.rvalid | m1_bus.rvalid), 0);
            end
        end
        chk("alt.cnt0", 32'(cnt0), 5);
        chk("alt.cnt1", 32'(cnt1), 5);

        // Reset with two reads in flight (m1 then m0, so m0 was granted last).
        @(negedge clk_g); drive(0, 0, 4'd0, 16'h0, 1, 0, 4'd5, 16'h0); #1;
        chk("mr.a.g1", 32'(m1_bus.gnt), 1);
        @(negedge clk_g); drive(1, 0, 4'd2, 16'h0, 0, 0, 4'd0, 16'h0); #1;
        chk("mr.b.g0", 32'(m0_bus.gnt), 1);
        @(negedge clk_g); rst = 1'b0; drive(1, 0, 4'd6, 16'h0, 1, 0, 4'd6, 16'h0); #1;
        chk("mr.c.g0", 32'(m0_bus.gnt), 0);
        chk("mr.c.g1", 32'(m1_bus.gnt), 0);
        @(negedge clk_g); rst = 1'b1; idle(); #1;
        chk("mr.d.ena", 32'(ena), 0);
        chk("mr.d.wea", 32'(wea), 0);
        chk("mr.d.addra", 32'(addra), 0);
        chk("mr.d.dina", 32'(dina), 0);
        chk("mr.d.rv0", 32'(m0_bus.rvalid), 0);
        chk("mr.d.rv1", 32'(m1_bus.rvalid), 0);
        chk("mr.d.rd0", 32'(m0_bus.rdata), 0);
        chk("mr.d.rd1", 32'(m1_bus.rdata), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_g); idle(); #1;
            chk($sformatf("mr.e%0d.rv", k), 32'(m0_bus.rvalid | m1_bus.rvalid), 0);
        end
        @(negedge clk_g); drive(1, 0, 4'd6, 16'h0, 1, 0, 4'd6, 16'h0); #1;
        chk("mr.g.g0", 32'(m0_bus.gnt), 1);
        chk("mr.g.g1", 32'(m1_bus.gnt), 0);
        // m1 withdraws its losing request here, leaving m0 as last granted.
        @(negedge clk_g); idle(); #1;
        chk("mr.h.g1", 32'(m1_bus.gnt), 0);
        @(negedge clk_g); idle(); #1;
        @(negedge clk_g); idle(); #1;
        chk("mr.j.rv0", 32'(m0_bus.rvalid), 1);
        chk("mr.j.rd0", 32'(m0_bus.rdata), 32'h0000C006);

        // Address wrap and withdrawal: m0 requests once while losing to m1.
        @(negedge clk_g); drive(1, 0, 4'd9, 16'h0, 1, 1, 4'd15, 16'hBEEF); #1;
        chk("wd.1.g0", 32'(m0_bus.gnt), 0);
        chk("wd.1.g1", 32'(m1_bus.gnt), 1);
        @(negedge clk_g); drive(0, 0, 4'd0, 16'h0, 1, 0, 4'd15, 16'h0); #1;
        chk("wd.2.g0", 32'(m0_bus.gnt), 0);
        chk("wd.2.g1", 32'(m1_bus.gnt), 1);
        chk("wd.2.ena", 32'(ena), 1);
        chk("wd.2.wea", 32'(wea), 1);
        chk("wd.2.addra", 32'(addra), 15);
        chk("wd.2.dina", 32'(dina), 32'h0000BEEF);
        @(negedge clk_g); idle(); #1;
        chk("wd.3.ena", 32'(ena), 1);
        chk("wd.3.wea", 32'(wea), 0);
        chk("wd.3.addra", 32'(addra), 15);
        @(negedge clk_g); idle(); #1;
        chk("wd.4.ena", 32'(ena), 0);
        @(negedge clk_g); idle(); #1;
        chk("wd.5.rv1", 32'(m1_bus.rvalid), 1);
        chk("wd.5.rd1", 32'(m1_bus.rdata), 32'h0000BEEF);
        chk("wd.5.rv0", 32'(m0_bus.rvalid), 0);
        chk("wd.5.rd0", 32'(m0_bus.rdata), 32'h0000C006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
